// File: rtl/radar_statistics_v2.sv
// radar_statistics_v2
//   Measures the antenna rotation period (ARP to ARP, in microsecond ticks),
//   the ACP and TRIG edge counts per rotation and a moving average of the
//   period over 2^AVG_LOG2 rotations. Every asynchronous input goes through a
//   2-flop synchroniser, a FILT_LEN-sample glitch filter and a rising-edge
//   detector. All four inputs see the same latency, so the order of edges
//   that are coincident on the pins is kept.
//
// Ports
//   SYS_CLK     in   system clock, rising edge
//   RST_N       in   synchronous active-low reset
//   ARP         in   azimuth reference pulse (async)
//   ACP         in   azimuth change pulse (async)
//   TRIG        in   radar trigger (async)
//   US_CLK      in   1 MHz reference (async), each rising edge is one tick
//   CALIBRATED  out  N rotations measured since the last arm
//   ARP_LOST    out  no ARP seen for TIMEOUT_US ticks
//   STAT_VALID  out  one-cycle strobe whenever the statistics below update
//   ARP_US      out  last rotation period in ticks
//   ARP_US_AVG  out  mean of the last N periods (zero-padded before N)
//   ACP_CNT     out  ACP edges in the last rotation
//   TRIG_CNT    out  TRIG edges in the last rotation
module radar_statistics_v2 #(
  parameter int DATA_WIDTH = 32,
  parameter int AVG_LOG2   = 2,
  parameter int FILT_LEN   = 3,
  parameter int TIMEOUT_US = 10000000
) (
  input  logic                  SYS_CLK,
  input  logic                  RST_N,
  input  logic                  ARP,
  input  logic                  ACP,
  input  logic                  TRIG,
  input  logic                  US_CLK,
  output logic                  CALIBRATED,
  output logic                  ARP_LOST,
  output logic                  STAT_VALID,
  output logic [DATA_WIDTH-1:0] ARP_US,
  output logic [DATA_WIDTH-1:0] ARP_US_AVG,
  output logic [DATA_WIDTH-1:0] ACP_CNT,
  output logic [DATA_WIDTH-1:0] TRIG_CNT
);

  localparam int N   = 1 << AVG_LOG2;
  localparam int SW  = DATA_WIDTH + AVG_LOG2;
  localparam int PW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FW  = AVG_LOG2 + 1;
  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  localparam logic [DATA_WIDTH-1:0] TIMEOUT_V = DATA_WIDTH'(TIMEOUT_US);

  localparam logic [0:0] S_WAIT_ARP = 1'b0;
  localparam logic [0:0] S_MEASURE  = 1'b1;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] v,
                                                     input logic en);
    if (en && (v != {DATA_WIDTH{1'b1}})) return v + DATA_WIDTH'(1);
    return v;
  endfunction

  // Channel order inside the 4-bit vectors: {US_CLK, TRIG, ACP, ARP}.
  logic [3:0]     pin;
  logic [3:0]     sync1_q, sync2_q;
  logic [3:0]     filt_q, filt_d, filt_dly_q;
  logic [FCW-1:0] fcnt_q [4];
  logic [FCW-1:0] fcnt_d [4];
  logic [3:0]     pulse;
  logic           arp_p, acp_p, trig_p, us_p;

  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] us_q, us_d, acp_q, acp_d, trig_q, trig_d;
  logic [DATA_WIDTH-1:0] us_inc, acp_inc, trig_inc;
  logic [DATA_WIDTH-1:0] arp_us_q, arp_us_d, acp_cnt_q, acp_cnt_d;
  logic [DATA_WIDTH-1:0] trig_cnt_q, trig_cnt_d, avg_q, avg_d;
  logic                  cal_q, cal_d, lost_q, lost_d, valid_q, valid_d;
  logic [DATA_WIDTH-1:0] buf_q [N];
  logic [DATA_WIDTH-1:0] buf_d [N];
  logic [SW-1:0]         sum_q, sum_d, sum_new;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [FW-1:0]         fill_q, fill_d;

  assign pin = {US_CLK, TRIG, ACP, ARP};

  // Stage: synchronised level -> filtered level. The filtered level flips only
  // after FILT_LEN consecutive samples that disagree with it.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FCW'(FILT_LEN - 1)) filt_d[i] = sync2_q[i];
        else                                 fcnt_d[i] = fcnt_q[i] + FCW'(1);
      end
    end
  end

  // Stage: filtered level -> one-cycle rising-edge pulse.
  assign pulse  = filt_q & ~filt_dly_q;
  assign arp_p  = pulse[0];
  assign acp_p  = pulse[1];
  assign trig_p = pulse[2];
  assign us_p   = pulse[3];

  // Pulses coincident with ARP are folded into the rotation that ARP closes.
  assign us_inc   = sat_inc(us_q, us_p);
  assign acp_inc  = sat_inc(acp_q, acp_p);
  assign trig_inc = sat_inc(trig_q, trig_p);

  // Stage: measurement FSM, publish and moving average.
  always_comb begin
    state_d    = state_q;
    us_d       = us_q;
    acp_d      = acp_q;
    trig_d     = trig_q;
    arp_us_d   = arp_us_q;
    acp_cnt_d  = acp_cnt_q;
    trig_cnt_d = trig_cnt_q;
    avg_d      = avg_q;
    cal_d      = cal_q;
    lost_d     = lost_q;
    valid_d    = 1'b0;
    sum_d      = sum_q;
    ptr_d      = ptr_q;
    fill_d     = fill_q;
    for (int i = 0; i < N; i++) buf_d[i] = buf_q[i];
    // Sum stays >= oldest entry, so the subtraction cannot underflow.
    sum_new = sum_q + SW'(us_inc) - SW'(buf_q[ptr_q]);

    case (state_q)
      S_WAIT_ARP: begin
        if (arp_p) begin
          state_d = S_MEASURE;
          lost_d  = 1'b0;
          cal_d   = 1'b0;
          fill_d  = '0;
          sum_d   = '0;
          ptr_d   = '0;
          us_d    = '0;
          acp_d   = '0;
          trig_d  = '0;
          for (int i = 0; i < N; i++) buf_d[i] = '0;
        end
      end
      default: begin
        if (arp_p) begin
          arp_us_d     = us_inc;
          acp_cnt_d    = acp_inc;
          trig_cnt_d   = trig_inc;
          valid_d      = 1'b1;
          us_d         = '0;
          acp_d        = '0;
          trig_d       = '0;
          sum_d        = sum_new;
          buf_d[ptr_q] = us_inc;
          ptr_d        = (ptr_q == PW'(N - 1)) ? '0 : ptr_q + PW'(1);
          fill_d       = (fill_q == FW'(N)) ? fill_q : fill_q + FW'(1);
          cal_d        = (fill_d == FW'(N));
          avg_d        = DATA_WIDTH'(sum_new >> AVG_LOG2);
        end else if (us_p && (us_inc == TIMEOUT_V)) begin
          // ARP loss: drop back to waiting, keep the last published values.
          state_d = S_WAIT_ARP;
          lost_d  = 1'b1;
          cal_d   = 1'b0;
          us_d    = '0;
          acp_d   = '0;
          trig_d  = '0;
        end else begin
          us_d   = us_inc;
          acp_d  = acp_inc;
          trig_d = trig_inc;
        end
      end
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (!RST_N) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
      for (int i = 0; i < 4; i++) fcnt_q[i] <= '0;
      state_q    <= S_WAIT_ARP;
      us_q       <= '0;
      acp_q      <= '0;
      trig_q     <= '0;
      arp_us_q   <= '0;
      acp_cnt_q  <= '0;
      trig_cnt_q <= '0;
      avg_q      <= '0;
      cal_q      <= 1'b0;
      lost_q     <= 1'b0;
      valid_q    <= 1'b0;
      sum_q      <= '0;
      ptr_q      <= '0;
      fill_q     <= '0;
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else begin
      sync1_q    <= pin;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      for (int i = 0; i < 4; i++) fcnt_q[i] <= fcnt_d[i];
      state_q    <= state_d;
      us_q       <= us_d;
      acp_q      <= acp_d;
      trig_q     <= trig_d;
      arp_us_q   <= arp_us_d;
      acp_cnt_q  <= acp_cnt_d;
      trig_cnt_q <= trig_cnt_d;
      avg_q      <= avg_d;
      cal_q      <= cal_d;
      lost_q     <= lost_d;
      valid_q    <= valid_d;
      sum_q      <= sum_d;
      ptr_q      <= ptr_d;
      fill_q     <= fill_d;
      for (int i = 0; i < N; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign CALIBRATED = cal_q;
  assign ARP_LOST   = lost_q;
  assign STAT_VALID = valid_q;
  assign ARP_US     = arp_us_q;
  assign ARP_US_AVG = avg_q;
  assign ACP_CNT    = acp_cnt_q;
  assign TRIG_CNT   = trig_cnt_q;

endmodule

// File: tb/tb_radar_statistics_v2.sv
// Bench for radar_statistics_v2. Instance A (32-bit, timeout 1000 ticks)
// covers nominal rotation, glitch filtering, mid-rotation reset and the
// moving average; instance B (8-bit, timeout 200 ticks) covers saturation,
// ARP loss and restart. Publishes are queued as expectations by the stimulus
// and popped by a monitor thread whenever STAT_VALID is seen.
module tb_radar_statistics_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic arp_a, acp_a, trig_a, us_a;
  logic arp_b, acp_b, trig_b, us_b;
  logic cal_a, lost_a, sv_a, cal_b, lost_b, sv_b;
  logic [31:0] us_o_a, avg_a, acpc_a, trigc_a;
  logic [7:0]  us_o_b, avg_b, acpc_b, trigc_b;

  radar_statistics_v2 #(.DATA_WIDTH(32), .AVG_LOG2(2), .FILT_LEN(3), .TIMEOUT_US(1000)) dut_a (
    .SYS_CLK(clk), .RST_N(rst_n), .ARP(arp_a), .ACP(acp_a), .TRIG(trig_a), .US_CLK(us_a),
    .CALIBRATED(cal_a), .ARP_LOST(lost_a), .STAT_VALID(sv_a), .ARP_US(us_o_a),
    .ARP_US_AVG(avg_a), .ACP_CNT(acpc_a), .TRIG_CNT(trigc_a));

  radar_statistics_v2 #(.DATA_WIDTH(8), .AVG_LOG2(2), .FILT_LEN(3), .TIMEOUT_US(200)) dut_b (
    .SYS_CLK(clk), .RST_N(rst_n), .ARP(arp_b), .ACP(acp_b), .TRIG(trig_b), .US_CLK(us_b),
    .CALIBRATED(cal_b), .ARP_LOST(lost_b), .STAT_VALID(sv_b), .ARP_US(us_o_b),
    .ARP_US_AVG(avg_b), .ACP_CNT(acpc_b), .TRIG_CNT(trigc_b));

  typedef struct {
    logic [31:0] us;
    logic [31:0] avg;
    logic [31:0] acp;
    logic [31:0] trig;
    logic        cal;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_chk;
  int   n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push_exp(input bit sel, input int us, input int avg, input int acp,
                          input int trig, input bit cal);
    exp_t e;
    e.us = us; e.avg = avg; e.acp = acp; e.trig = trig; e.cal = cal;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  // Drives one block of len cycles. Each periodic signal rises at c=0 and
  // every p cycles after (high p/2 cycles); p=0 keeps it low. ARP, if
  // enabled, is high for cycles 0..3. An extra ACP pulse of g_w cycles
  // starts at c=g_at.
  task automatic drive(input bit sel, input int len, input bit arp_en, input int us_p,
                       input int acp_p, input int trig_p, input int g_at, input int g_w);
    logic a, u, ac, t;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      a  = arp_en && (c < 4);
      u  = (us_p > 0) && ((c % us_p) < us_p / 2);
      ac = ((acp_p > 0) && ((c % acp_p) < acp_p / 2)) || ((c >= g_at) && (c < g_at + g_w));
      t  = (trig_p > 0) && ((c % trig_p) < trig_p / 2);
      if (sel) begin arp_b = a; us_b = u; acp_b = ac; trig_b = t; end
      else     begin arp_a = a; us_a = u; acp_a = ac; trig_a = t; end
    end
  endtask

  task automatic monitor();
    logic pa = 1'b0;
    logic pb = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (sv_a) begin
        check("a_sv_single_cycle", {31'b0, pa}, 32'd0);
        if (q_a.size() == 0) begin
          n_chk++;
          $display("FAIL a_unexpected_pub: STAT_VALID with ARP_US=%0d, none expected", us_o_a);
        end else begin
          e = q_a.pop_front();
          check("a_arp_us", us_o_a, e.us);
          check("a_arp_us_avg", avg_a, e.avg);
          check("a_acp_cnt", acpc_a, e.acp);
          check("a_trig_cnt", trigc_a, e.trig);
          check("a_calibrated_pub", {31'b0, cal_a}, {31'b0, e.cal});
        end
      end
      if (sv_b) begin
        check("b_sv_single_cycle", {31'b0, pb}, 32'd0);
        if (q_b.size() == 0) begin
          n_chk++;
          $display("FAIL b_unexpected_pub: STAT_VALID with ARP_US=%0d, none expected", us_o_b);
        end else begin
          e = q_b.pop_front();
          check("b_arp_us", {24'b0, us_o_b}, e.us);
          check("b_arp_us_avg", {24'b0, avg_b}, e.avg);
          check("b_acp_cnt", {24'b0, acpc_b}, e.acp);
          check("b_trig_cnt", {24'b0, trigc_b}, e.trig);
          check("b_calibrated_pub", {31'b0, cal_b}, {31'b0, e.cal});
        end
      end
      pa = sv_a;
      pb = sv_b;
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0;
    arp_a = 0; acp_a = 0; trig_a = 0; us_a = 0;
    arp_b = 0; acp_b = 0; trig_b = 0; us_b = 0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cal", {31'b0, cal_a}, 32'd0);
    check("rst_lost", {31'b0, lost_a}, 32'd0);
    check("rst_sv", {31'b0, sv_a}, 32'd0);
    check("rst_arp_us", us_o_a, 32'd0);
    check("rst_avg", avg_a, 32'd0);
    check("rst_acp", acpc_a, 32'd0);
    check("rst_trig", trigc_a, 32'd0);
    check("rst_b_lost", {31'b0, lost_b}, 32'd0);
    rst_n = 1'b1;

    // Nominal: 125 ticks, 5 ACP, 25 TRIG per rotation
    drive(0, 1250, 1, 10, 250, 50, 0, 0);
    push_exp(0, 125, 31, 5, 25, 0);  drive(0, 1250, 1, 10, 250, 50, 0, 0);
    push_exp(0, 125, 62, 5, 25, 0);  drive(0, 1250, 1, 10, 250, 50, 0, 0);
    push_exp(0, 125, 93, 5, 25, 0);  drive(0, 1250, 1, 10, 250, 50, 0, 0);
    push_exp(0, 125, 125, 5, 25, 1); drive(0, 1250, 1, 10, 250, 50, 0, 0);
    check("a_calibrated_after_5th", {31'b0, cal_a}, 32'd1);
    check("a_avg_after_5th", avg_a, 32'd125);

    // Glitch: 2-cycle ACP pulse ignored, 3-cycle pulse counted
    push_exp(0, 125, 125, 5, 25, 1); drive(0, 1250, 1, 10, 250, 50, 150, 2);
    push_exp(0, 125, 125, 5, 25, 1); drive(0, 1250, 1, 10, 250, 50, 150, 3);
    push_exp(0, 125, 125, 6, 25, 1); drive(0, 1250, 1, 10, 250, 50, 0, 0);

    // Reset for one cycle mid-rotation
    drive(0, 600, 0, 10, 250, 50, 0, 0);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check("mid_rst_cal", {31'b0, cal_a}, 32'd0);
    check("mid_rst_lost", {31'b0, lost_a}, 32'd0);
    check("mid_rst_arp_us", us_o_a, 32'd0);
    check("mid_rst_avg", avg_a, 32'd0);
    check("mid_rst_acp", acpc_a, 32'd0);
    check("mid_rst_trig", trigc_a, 32'd0);

    // Averaging over periods 100..500; the first ARP after reset only arms
    drive(0, 800, 1, 8, 0, 0, 0, 0);
    push_exp(0, 100, 25, 0, 0, 0);  drive(0, 1600, 1, 8, 0, 0, 0, 0);
    push_exp(0, 200, 75, 0, 0, 0);  drive(0, 2400, 1, 8, 0, 0, 0, 0);
    push_exp(0, 300, 150, 0, 0, 0); drive(0, 3200, 1, 8, 0, 0, 0, 0);
    push_exp(0, 400, 250, 0, 0, 1); drive(0, 4000, 1, 8, 0, 0, 0, 0);
    push_exp(0, 500, 350, 0, 0, 1); drive(0, 80, 1, 8, 0, 0, 0, 0);

    // Saturation (8-bit): 150 ticks, 300 ACP -> 255, 60 TRIG
    drive(1, 3000, 1, 20, 10, 50, 0, 0);
    push_exp(1, 150, 37, 255, 60, 0);  drive(1, 3000, 1, 20, 10, 50, 0, 0);
    push_exp(1, 150, 75, 255, 60, 0);  drive(1, 3000, 1, 20, 10, 50, 0, 0);
    push_exp(1, 150, 112, 255, 60, 0); drive(1, 3000, 1, 20, 10, 50, 0, 0);
    push_exp(1, 150, 150, 255, 60, 1); drive(1, 3000, 1, 20, 10, 50, 0, 0);

    // Timeout: tick 199 after last ARP, then tick 200
    drive(1, 1000, 0, 20, 0, 0, 0, 0);
    check("b_lost_before_timeout", {31'b0, lost_b}, 32'd0);
    check("b_cal_before_timeout", {31'b0, cal_b}, 32'd1);
    drive(1, 20, 0, 20, 0, 0, 0, 0);
    check("b_lost_at_timeout", {31'b0, lost_b}, 32'd1);
    check("b_cal_at_timeout", {31'b0, cal_b}, 32'd0);
    check("b_hold_arp_us", {24'b0, us_o_b}, 32'd150);
    check("b_hold_avg", {24'b0, avg_b}, 32'd150);
    check("b_hold_acp", {24'b0, acpc_b}, 32'd255);
    check("b_hold_trig", {24'b0, trigc_b}, 32'd60);

    // Restart: first ARP clears loss and arms, second publishes
    drive(1, 2000, 1, 20, 10, 50, 0, 0);
    check("b_lost_cleared", {31'b0, lost_b}, 32'd0);
    push_exp(1, 100, 25, 200, 40, 0); drive(1, 200, 1, 20, 10, 50, 0, 0);
    drive(1, 40, 0, 0, 0, 0, 0, 0);

    check("a_queue_drained", q_a.size(), 32'd0);
    check("b_queue_drained", q_b.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
